// File: rtl/wbchk_pkg.sv
// Shared types for the writeback-trace checker: FSM/fail encodings and the golden-trace entry.
// XLEN/REG_AW of the checker must match PKG_XLEN/PKG_REG_AW because entries are a packed struct.
package wbchk_pkg;

    localparam int PKG_XLEN   = 32;
    localparam int PKG_REG_AW = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } chk_state_e;

    typedef enum logic [1:0] {
        FK_NONE = 2'd0,
        FK_PC   = 2'd1,
        FK_REG  = 2'd2,
        FK_VAL  = 2'd3
    } fail_kind_e;

    typedef struct packed {
        logic [PKG_XLEN-1:0]   pc;
        logic [PKG_REG_AW-1:0] rd;
        logic [PKG_XLEN-1:0]   val;
        logic                  last;
    } wb_entry_t;

    // Priority: missing/PC first, then register, then value.
    function automatic fail_kind_e classify(
        input wb_entry_t             head,
        input logic                  empty,
        input logic [PKG_XLEN-1:0]   pc,
        input logic [PKG_REG_AW-1:0] rd,
        input logic [PKG_XLEN-1:0]   val
    );
        if (empty || head.pc != pc) return FK_PC;
        if (head.rd != rd)          return FK_REG;
        if (head.val != val)        return FK_VAL;
        return FK_NONE;
    endfunction

endpackage

// File: rtl/wb_trace_checker_if.sv
// Loader + debug writeback + result bus of the trace checker.
// master = bench/boot ROM and CPU side, slave = the checker.
interface wb_trace_checker_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              check_start;
    logic              exp_valid;
    logic              exp_ready;
    logic [XLEN-1:0]   exp_pc;
    logic [REG_AW-1:0] exp_reg;
    logic [XLEN-1:0]   exp_val;
    logic              exp_last;
    logic              debug_wb_ena;
    logic [XLEN-1:0]   debug_wb_pc;
    logic [REG_AW-1:0] debug_wb_reg;
    logic [XLEN-1:0]   debug_wb_value;
    logic [1:0]        chk_state;
    logic [CNT_W-1:0]  pass_cnt;
    logic [1:0]        fail_kind;
    logic [XLEN-1:0]   fail_pc;
    logic [XLEN-1:0]   fail_exp;
    logic [XLEN-1:0]   fail_got;
    logic [LVL_W-1:0]  fill_lvl;

    modport master (
        output check_start, exp_valid, exp_pc, exp_reg, exp_val, exp_last,
               debug_wb_ena, debug_wb_pc, debug_wb_reg, debug_wb_value,
        input  exp_ready, chk_state, pass_cnt, fail_kind, fail_pc, fail_exp, fail_got, fill_lvl
    );

    modport slave (
        input  check_start, exp_valid, exp_pc, exp_reg, exp_val, exp_last,
               debug_wb_ena, debug_wb_pc, debug_wb_reg, debug_wb_value,
        output exp_ready, chk_state, pass_cnt, fail_kind, fail_pc, fail_exp, fail_got, fill_lvl
    );

endinterface

// File: rtl/wbchk_fifo.sv
// Synchronous FIFO of golden-trace entries; head is the registered oldest entry.
// A push while full is dropped even if a pop happens in the same cycle.
module wbchk_fifo
    import wbchk_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       push_i,
    input  wb_entry_t  din_i,
    input  logic       pop_i,
    output wb_entry_t  head_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [AW:0] level_o
);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    wb_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW + 1)'(1);
            2'b01:   level_d = level_q - (AW + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push && !srst) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/wb_trace_checker.sv
// Writeback-trace scoreboard: compares debug_wb_* against a golden FIFO, latches the first mismatch.
// Optional watchdog under `WBCHK_TIMEOUT_EN fails the run after TIMEOUT_CYC writeback-free cycles.
module wb_trace_checker
    import wbchk_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int REG_AW      = 5,
    parameter int DEPTH       = 16,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 512
) (
    input  logic                 cpu_clk,
    input  logic                 cpu_rst,
    wb_trace_checker_if.slave    bus
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("wb_trace_checker: DEPTH must be a power of two >= 2 and TIMEOUT_CYC >= 1");
    end

    chk_state_e        state_q, state_d;
    fail_kind_e        kind_now;
    fail_kind_e        fail_kind_q, fail_kind_d;
    logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic [XLEN-1:0]   fail_pc_q, fail_pc_d;
    logic [XLEN-1:0]   fail_exp_q, fail_exp_d;
    logic [XLEN-1:0]   fail_got_q, fail_got_d;
    logic [REG_AW-1:0] wb_rd;
    wb_entry_t         head, push_entry;
    logic [LVL_W-1:0]  level;
    logic              fifo_full, fifo_empty, push_en, pop_en, wb_event, timeout_hit;

    assign push_entry = '{pc: bus.exp_pc, rd: bus.exp_reg, val: bus.exp_val, last: bus.exp_last};
    assign push_en    = bus.exp_valid && (state_q != ST_FAIL);
    assign wb_rd      = bus.debug_wb_reg;
    assign wb_event   = (state_q == ST_RUN) && bus.debug_wb_ena && (wb_rd != '0);
    assign kind_now   = classify(head, fifo_empty, bus.debug_wb_pc, wb_rd, bus.debug_wb_value);
    assign pop_en     = wb_event && (kind_now == FK_NONE);

    wbchk_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (cpu_clk),
        .srst    (cpu_rst),
        .push_i  (push_en),
        .din_i   (push_entry),
        .pop_i   (pop_en),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

`ifdef WBCHK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] quiet_cnt_q;

    // Counts RUN cycles since the last event; the TIMEOUT_CYC-th quiet edge fails the run.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst || state_q != ST_RUN || wb_event) begin
            quiet_cnt_q <= '0;
        end else begin
            quiet_cnt_q <= quiet_cnt_q + TW'(1);
        end
    end

    assign timeout_hit = (state_q == ST_RUN) && !wb_event && (quiet_cnt_q == TW'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q     <= ST_IDLE;
            pass_cnt_q  <= '0;
            fail_kind_q <= FK_NONE;
            fail_pc_q   <= '0;
            fail_exp_q  <= '0;
            fail_got_q  <= '0;
        end else begin
            state_q     <= state_d;
            pass_cnt_q  <= pass_cnt_d;
            fail_kind_q <= fail_kind_d;
            fail_pc_q   <= fail_pc_d;
            fail_exp_q  <= fail_exp_d;
            fail_got_q  <= fail_got_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.check_start) state_d = ST_RUN;
            ST_RUN: begin
                if (wb_event) begin
                    if (kind_now != FK_NONE) state_d = ST_FAIL;
                    else if (head.last)      state_d = ST_PASS;
                end else if (timeout_hit) begin
                    state_d = ST_FAIL;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // Failure capture only happens from RUN, so the fail_* registers freeze once FAIL is entered.
    always_comb begin
        pass_cnt_d  = pass_cnt_q;
        fail_kind_d = fail_kind_q;
        fail_pc_d   = fail_pc_q;
        fail_exp_d  = fail_exp_q;
        fail_got_d  = fail_got_q;
        if (pop_en && pass_cnt_q != '1) begin
            pass_cnt_d = pass_cnt_q + CNT_W'(1);
        end
        if (wb_event && kind_now != FK_NONE) begin
            fail_kind_d = kind_now;
            fail_pc_d   = bus.debug_wb_pc;
            fail_exp_d  = fifo_empty ? '0 : head.val;
            fail_got_d  = bus.debug_wb_value;
        end else if (timeout_hit) begin
            fail_kind_d = FK_PC;
            fail_pc_d   = fifo_empty ? '0 : head.pc;
            fail_exp_d  = fifo_empty ? '0 : head.val;
            fail_got_d  = '0;
        end
    end

    assign bus.exp_ready = !fifo_full;
    assign bus.chk_state = state_q;
    assign bus.pass_cnt  = pass_cnt_q;
    assign bus.fail_kind = fail_kind_q;
    assign bus.fail_pc   = fail_pc_q;
    assign bus.fail_exp  = fail_exp_q;
    assign bus.fail_got  = fail_got_q;
    assign bus.fill_lvl  = level;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Self-checking bench for wb_trace_checker: directed scenarios plus randomized traces vs a queue model.
// Define WBCHK_TIMEOUT_EN for both RTL and bench to exercise the watchdog scenario.
module tb_wb_trace_checker;
    import wbchk_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int TMO   = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_trace_checker_if #(.XLEN(32), .REG_AW(5), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    wb_trace_checker #(
        .XLEN(32), .REG_AW(5), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT_CYC(TMO)
    ) dut (
        .cpu_clk (clk),
        .cpu_rst (rst),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: state number, queue of pending entries, latched failure data.
    int               m_state;
    wb_entry_t        m_q[$];
    logic [CNT_W-1:0] m_pass;
    int               m_kind;
    logic [31:0]      m_fpc, m_fexp, m_fgot;
    int               m_quiet;

    task automatic clear_inputs();
        bus.check_start    = 1'b0;
        bus.exp_valid      = 1'b0;
        bus.exp_pc         = '0;
        bus.exp_reg        = '0;
        bus.exp_val        = '0;
        bus.exp_last       = 1'b0;
        bus.debug_wb_ena   = 1'b0;
        bus.debug_wb_pc    = '0;
        bus.debug_wb_reg   = '0;
        bus.debug_wb_value = '0;
    endtask

    task automatic model_fail(int k, logic [31:0] pc, logic [31:0] e, logic [31:0] g);
        m_state = 3; m_kind = k; m_fpc = pc; m_fexp = e; m_fgot = g;
    endtask

    // Advance the model from the current inputs, then clock the DUT and settle.
    task automatic tick();
        int        old;
        bit        ev, can_push;
        wb_entry_t e;
        old      = m_state;
        ev       = (old == 1) && bus.debug_wb_ena && (bus.debug_wb_reg != 0);
        can_push = bus.exp_valid && (m_q.size() < DEPTH) && (old != 3);
        e        = '{pc: bus.exp_pc, rd: bus.exp_reg, val: bus.exp_val, last: bus.exp_last};
        if (rst) begin
            m_state = 0; m_q.delete(); m_pass = '0; m_kind = 0;
            m_fpc = '0; m_fexp = '0; m_fgot = '0; m_quiet = 0;
        end else begin
            if (ev) begin
                m_quiet = 0;
                if (m_q.size() == 0)                      model_fail(1, bus.debug_wb_pc, 0, bus.debug_wb_value);
                else if (m_q[0].pc != bus.debug_wb_pc)    model_fail(1, bus.debug_wb_pc, m_q[0].val, bus.debug_wb_value);
                else if (m_q[0].rd != bus.debug_wb_reg)   model_fail(2, bus.debug_wb_pc, m_q[0].val, bus.debug_wb_value);
                else if (m_q[0].val != bus.debug_wb_value) model_fail(3, bus.debug_wb_pc, m_q[0].val, bus.debug_wb_value);
                else begin
                    if (m_pass != '1) m_pass = m_pass + 1'b1;
                    if (m_q[0].last) m_state = 2;
                    void'(m_q.pop_front());
                end
            end else if (old == 1) begin
`ifdef WBCHK_TIMEOUT_EN
                m_quiet++;
                if (m_quiet == TMO) begin
                    if (m_q.size() == 0) model_fail(1, 0, 0, 0);
                    else                 model_fail(1, m_q[0].pc, m_q[0].val, 0);
                end
`endif
            end
            if (old != 1) m_quiet = 0;
            if (can_push) m_q.push_back(e);
            if (old == 0 && bus.check_start) m_state = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push(logic [31:0] pc, logic [4:0] rd, logic [31:0] v, logic last);
        bus.exp_valid = 1'b1; bus.exp_pc = pc; bus.exp_reg = rd; bus.exp_val = v; bus.exp_last = last;
        $display("push pc=%08h reg=x%0d val=%08h last=%0d ready=%0d", pc, rd, v, last, bus.exp_ready);
        tick();
        bus.exp_valid = 1'b0; bus.exp_last = 1'b0;
    endtask

    task automatic wb(logic [31:0] pc, logic [4:0] rd, logic [31:0] v);
        bus.debug_wb_ena = 1'b1; bus.debug_wb_pc = pc; bus.debug_wb_reg = rd; bus.debug_wb_value = v;
        tick();
        bus.debug_wb_ena = 1'b0;
        $display("wb   pc=%08h reg=x%0d val=%08h -> state=%0d pass=%0d kind=%0d", pc, rd, v,
                 bus.chk_state, bus.pass_cnt, bus.fail_kind);
    endtask

    task automatic start();
        bus.check_start = 1'b1;
        tick();
        bus.check_start = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (bus.chk_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", bus.chk_state); end
        checks++; if (bus.pass_cnt !== '0) begin failures++; $display("FAIL reset_pass got=%0d want=0", bus.pass_cnt); end
        checks++; if (bus.fail_kind !== 2'd0 || bus.fail_pc !== 32'd0 || bus.fail_exp !== 32'd0 || bus.fail_got !== 32'd0) begin
            failures++; $display("FAIL reset_fail_regs got=%0d/%h/%h/%h want=0", bus.fail_kind, bus.fail_pc, bus.fail_exp, bus.fail_got); end
        checks++; if (bus.exp_ready !== 1'b1 || bus.fill_lvl !== '0) begin
            failures++; $display("FAIL reset_fifo got ready=%0d lvl=%0d want ready=1 lvl=0", bus.exp_ready, bus.fill_lvl); end
    endtask

    task automatic test_match_trace();
        do_reset();
        push(32'h00, 5'd1, 32'd10, 1'b0);
        push(32'h04, 5'd2, 32'hFFFF_FFFB, 1'b0);
        push(32'h08, 5'd3, 32'd5, 1'b1);
        checks++; if (bus.fill_lvl !== 3'd3) begin failures++; $display("FAIL trace_fill got=%0d want=3", bus.fill_lvl); end
        start();
        checks++; if (bus.chk_state !== 2'd1) begin failures++; $display("FAIL trace_run got=%0d want=1", bus.chk_state); end
        wb(32'h00, 5'd1, 32'd10);
        checks++; if (bus.pass_cnt !== 16'd1) begin failures++; $display("FAIL trace_pass1 got=%0d want=1", bus.pass_cnt); end
        wb(32'h04, 5'd2, 32'hFFFF_FFFB);
        wb(32'h08, 5'd3, 32'd5);
        checks++; if (bus.pass_cnt !== 16'd3) begin failures++; $display("FAIL trace_pass3 got=%0d want=3", bus.pass_cnt); end
        checks++; if (bus.chk_state !== 2'd2) begin failures++; $display("FAIL trace_pass_state got=%0d want=2", bus.chk_state); end
        checks++; if (bus.fail_kind !== 2'd0) begin failures++; $display("FAIL trace_kind got=%0d want=0", bus.fail_kind); end
        wb(32'h0C, 5'd4, 32'd99);
        checks++; if (bus.chk_state !== 2'd2 || bus.fail_kind !== 2'd0 || bus.pass_cnt !== 16'd3) begin
            failures++; $display("FAIL after_pass got state=%0d kind=%0d pass=%0d want 2/0/3", bus.chk_state, bus.fail_kind, bus.pass_cnt); end
    endtask

    task automatic test_value_mismatch();
        do_reset();
        push(32'h0C, 5'd4, 32'd15, 1'b0);
        start();
        wb(32'h0C, 5'd4, 32'd14);
        checks++; if (bus.chk_state !== 2'd3 || bus.fail_kind !== 2'd3) begin
            failures++; $display("FAIL val_kind got state=%0d kind=%0d want 3/3", bus.chk_state, bus.fail_kind); end
        checks++; if (bus.fail_exp !== 32'd15 || bus.fail_got !== 32'd14 || bus.fail_pc !== 32'h0C) begin
            failures++; $display("FAIL val_data got exp=%0d got=%0d pc=%h want 15/14/0c", bus.fail_exp, bus.fail_got, bus.fail_pc); end
        push(32'h10, 5'd5, 32'd1, 1'b1);
        checks++; if (bus.fill_lvl !== 3'd1) begin failures++; $display("FAIL fail_push got=%0d want=1", bus.fill_lvl); end
        wb(32'h10, 5'd5, 32'd77);
        checks++; if (bus.fail_got !== 32'd14 || bus.fail_pc !== 32'h0C || bus.fail_kind !== 2'd3) begin
            failures++; $display("FAIL fail_freeze got got=%0d pc=%h kind=%0d want 14/0c/3", bus.fail_got, bus.fail_pc, bus.fail_kind); end
    endtask

    task automatic test_pc_reg_mismatch();
        do_reset();
        push(32'h54, 5'd19, 32'd1, 1'b1);
        start();
        wb(32'h50, 5'd19, 32'd1);
        checks++; if (bus.chk_state !== 2'd3 || bus.fail_kind !== 2'd1 || bus.fail_pc !== 32'h50) begin
            failures++; $display("FAIL pc_mismatch got state=%0d kind=%0d pc=%h want 3/1/50", bus.chk_state, bus.fail_kind, bus.fail_pc); end
        do_reset();
        push(32'h60, 5'd7, 32'd3, 1'b1);
        start();
        wb(32'h60, 5'd8, 32'd3);
        checks++; if (bus.fail_kind !== 2'd2 || bus.fail_exp !== 32'd3) begin
            failures++; $display("FAIL reg_mismatch got kind=%0d exp=%0d want 2/3", bus.fail_kind, bus.fail_exp); end
        do_reset();
        start();
        wb(32'h70, 5'd1, 32'd5);
        checks++; if (bus.fail_kind !== 2'd1 || bus.fail_exp !== 32'd0 || bus.fail_got !== 32'd5) begin
            failures++; $display("FAIL empty_fifo got kind=%0d exp=%0d got=%0d want 1/0/5", bus.fail_kind, bus.fail_exp, bus.fail_got); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(32'(i * 4), 5'(i + 1), 32'(i * 3), 1'b0);
        checks++; if (bus.exp_ready !== 1'b0 || bus.fill_lvl !== 3'(DEPTH)) begin
            failures++; $display("FAIL full got ready=%0d lvl=%0d want 0/%0d", bus.exp_ready, bus.fill_lvl, DEPTH); end
        start();
        bus.exp_valid = 1'b1; bus.exp_pc = 32'h40; bus.exp_reg = 5'd9; bus.exp_val = 32'd9;
        bus.debug_wb_ena = 1'b1; bus.debug_wb_pc = 32'h0; bus.debug_wb_reg = 5'd1; bus.debug_wb_value = 32'd0;
        checks++; if (bus.exp_ready !== 1'b0) begin failures++; $display("FAIL full_same_cycle got ready=%0d want 0", bus.exp_ready); end
        tick();
        clear_inputs();
        checks++; if (bus.fill_lvl !== 3'(DEPTH - 1) || bus.exp_ready !== 1'b1 || bus.pass_cnt !== 16'd1) begin
            failures++; $display("FAIL full_pop got lvl=%0d ready=%0d pass=%0d want %0d/1/1", bus.fill_lvl, bus.exp_ready, bus.pass_cnt, DEPTH - 1); end
        push(32'h40, 5'd9, 32'd9, 1'b0);
        checks++; if (bus.fill_lvl !== 3'(DEPTH)) begin failures++; $display("FAIL full_refill got=%0d want=%0d", bus.fill_lvl, DEPTH); end
    endtask

    task automatic test_x0_and_reset();
        do_reset();
        push(32'h80, 5'd1, 32'd1, 1'b0);
        push(32'h84, 5'd2, 32'd2, 1'b0);
        start();
        wb(32'h8C, 5'd0, 32'h90);
        checks++; if (bus.pass_cnt !== 16'd0 || bus.chk_state !== 2'd1 || bus.fill_lvl !== 3'd2) begin
            failures++; $display("FAIL x0_first got pass=%0d state=%0d lvl=%0d want 0/1/2", bus.pass_cnt, bus.chk_state, bus.fill_lvl); end
        wb(32'h80, 5'd1, 32'd1);
        wb(32'h8C, 5'd0, 32'h90);
        checks++; if (bus.pass_cnt !== 16'd1 || bus.chk_state !== 2'd1) begin
            failures++; $display("FAIL x0_second got pass=%0d state=%0d want 1/1", bus.pass_cnt, bus.chk_state); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.chk_state !== 2'd0 || bus.pass_cnt !== 16'd0 || bus.fill_lvl !== 3'd0 || bus.exp_ready !== 1'b1 || bus.fail_kind !== 2'd0) begin
            failures++; $display("FAIL midrun_reset got state=%0d pass=%0d lvl=%0d ready=%0d kind=%0d want 0/0/0/1/0",
                                 bus.chk_state, bus.pass_cnt, bus.fill_lvl, bus.exp_ready, bus.fail_kind); end
    endtask

    task automatic test_timeout();
        do_reset();
        push(32'h100, 5'd5, 32'd7, 1'b1);
        start();
`ifdef WBCHK_TIMEOUT_EN
        for (int i = 1; i < TMO; i++) tick();
        checks++; if (bus.chk_state !== 2'd1) begin failures++; $display("FAIL timeout_early got=%0d want=1", bus.chk_state); end
        tick();
        checks++; if (bus.chk_state !== 2'd3 || bus.fail_kind !== 2'd1 || bus.fail_pc !== 32'h100) begin
            failures++; $display("FAIL timeout got state=%0d kind=%0d pc=%h want 3/1/100", bus.chk_state, bus.fail_kind, bus.fail_pc); end
`else
        for (int i = 0; i < 3 * TMO; i++) tick();
        checks++; if (bus.chk_state !== 2'd1) begin failures++; $display("FAIL no_timeout got=%0d want=1", bus.chk_state); end
`endif
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            wb_entry_t tr[$];
            int  n, np, nw, r;
            bit  started, pushed, issued;
            do_reset();
            n = $urandom_range(1, 7);
            np = 0; nw = 0; started = 0;
            for (int k = 0; k < n; k++)
                tr.push_back('{pc: 32'($urandom) & 32'hFFFF_FFFC, rd: 5'($urandom_range(1, 31)),
                               val: 32'($urandom), last: (k == n - 1)});
            for (int cyc = 0; cyc < 80 && m_state != 2 && m_state != 3; cyc++) begin
                clear_inputs();
                if (np < n && $urandom_range(0, 1) == 1) begin
                    bus.exp_valid = 1'b1; bus.exp_pc = tr[np].pc; bus.exp_reg = tr[np].rd;
                    bus.exp_val = tr[np].val; bus.exp_last = tr[np].last;
                end
                if (!started && $urandom_range(0, 3) == 0) bus.check_start = 1'b1;
                r = $urandom_range(0, 19);
                if ((r < 8 && nw < np && nw < n) || (r == 8 && nw < n)) begin
                    bus.debug_wb_ena = 1'b1; bus.debug_wb_pc = tr[nw].pc;
                    bus.debug_wb_reg = tr[nw].rd; bus.debug_wb_value = tr[nw].val;
                    case ($urandom_range(0, 15))
                        0: bus.debug_wb_pc = tr[nw].pc + 32'd4;
                        1: bus.debug_wb_reg = (tr[nw].rd % 5'd31) + 5'd1;
                        2: bus.debug_wb_value = ~tr[nw].val;
                        default: ;
                    endcase
                end else if (r == 9) begin
                    bus.debug_wb_ena = 1'b1; bus.debug_wb_pc = 32'($urandom);
                    bus.debug_wb_reg = 5'd0; bus.debug_wb_value = 32'($urandom);
                end
                pushed = bus.exp_valid && (m_q.size() < DEPTH) && (m_state != 3);
                issued = bus.debug_wb_ena && (bus.debug_wb_reg != 0) && (m_state == 1);
                tick();
                np += int'(pushed);
                nw += int'(issued);
                started = started || (m_state != 0);
                checks++; if (bus.chk_state !== 2'(m_state)) begin
                    failures++; $display("FAIL rnd_state it=%0d cyc=%0d got=%0d want=%0d", it, cyc, bus.chk_state, m_state); end
                checks++; if (bus.pass_cnt !== m_pass || bus.fill_lvl !== 3'(m_q.size()) || bus.exp_ready !== (m_q.size() < DEPTH)) begin
                    failures++; $display("FAIL rnd_count it=%0d cyc=%0d got pass=%0d lvl=%0d ready=%0d want %0d/%0d/%0d", it, cyc,
                                         bus.pass_cnt, bus.fill_lvl, bus.exp_ready, m_pass, m_q.size(), m_q.size() < DEPTH); end
                checks++; if (bus.fail_kind !== 2'(m_kind) || bus.fail_pc !== m_fpc || bus.fail_exp !== m_fexp || bus.fail_got !== m_fgot) begin
                    failures++; $display("FAIL rnd_fail it=%0d cyc=%0d got %0d/%h/%h/%h want %0d/%h/%h/%h", it, cyc, bus.fail_kind,
                                         bus.fail_pc, bus.fail_exp, bus.fail_got, m_kind, m_fpc, m_fexp, m_fgot); end
            end
            $display("rnd  it=%0d len=%0d pushed=%0d wbs=%0d state=%0d pass=%0d kind=%0d", it, n, np, nw,
                     bus.chk_state, bus.pass_cnt, bus.fail_kind);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_match_trace();
        test_value_mismatch();
        test_pc_reg_mismatch();
        test_full();
        test_x0_and_reset();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_trace_checker.md
Name: wb_trace_checker

Overview:
Synthesisable writeback-trace scoreboard for myCPU bring-up. It replaces hard-coded per-PC checks with a parametrised golden-trace FIFO. A loader (bench or boot ROM) streams expected {pc, reg, value} entries in. The checker compares them in order against the DUT debug writeback port, keeps pass/fail counters, and latches the first mismatch for readout. The block sits beside myCPU, on the debug_wb_* bus.

Parameters:
XLEN, 32, data and PC width
REG_AW, 5, register index width
DEPTH, 16, expected-entry FIFO depth (power of two, at least 2)
CNT_W, 16, pass/fail counter width
TIMEOUT_CYC, 512, watchdog limit in cycles without a writeback (used only with the macro)

Ports:
cpu_clk  in  1  clock
cpu_rst  in  1  synchronous, active-high reset
check_start  in  1  one-cycle pulse, IDLE->RUN
exp_valid  in  1  expected entry offered
exp_ready  out  1  FIFO can accept an entry
exp_pc  in  XLEN  expected writeback PC
exp_reg  in  REG_AW  expected destination register
exp_val  in  XLEN  expected writeback value
exp_last  in  1  marks the final entry of the trace
debug_wb_ena  in  1  DUT writeback enable
debug_wb_pc  in  XLEN  DUT writeback PC
debug_wb_reg  in  REG_AW  DUT destination register
debug_wb_value  in  XLEN  DUT writeback value
chk_state  out  2  0 IDLE, 1 RUN, 2 PASS, 3 FAIL
pass_cnt  out  CNT_W  matched writebacks
fail_kind  out  2  0 none, 1 PC/unexpected, 2 reg, 3 value
fail_pc  out  XLEN  DUT PC of first failure
fail_exp  out  XLEN  expected value at first failure
fail_got  out  XLEN  DUT value at first failure
fill_lvl  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (cpu_rst=1 at a cpu_clk edge): state IDLE, FIFO empty, all counters and fail_* are 0, exp_ready=1. Reset mid-run aborts the check; it does not preserve results.
- Push: exp_valid && exp_ready. exp_ready = !full. Pushes are accepted in every state except FAIL.
- Event: debug_wb_ena && debug_wb_reg != 0 while in RUN. Writebacks to x0 are ignored in every state.
- Compare: the event is compared against the FIFO head as registered at the start of the cycle. An entry pushed in the same cycle is not visible to that event.
- Check order:
  - FIFO empty -> fail_kind 1
  - PC mismatch -> 1
  - reg mismatch -> 2
  - value mismatch -> 3
  - otherwise match.
- On a match: pop the head and increment pass_cnt (saturates at all-ones). If the popped entry had last=1, go to PASS.
- On a failure: go to FAIL. fail_kind, fail_pc, fail_exp and fail_got update one cycle after the event and then freeze. fail_exp is the head value, or 0 when the FIFO was empty.
- Result latency: chk_state and pass_cnt reflect an event one cycle after it.
- Simultaneous push and pop when full: the pop frees a slot next cycle only. exp_ready remains 0 that cycle.
- check_start outside IDLE is ignored.
- Events in IDLE are ignored, and so are events after PASS. PASS and FAIL are terminal until reset.

Optional Feature:
WBCHK_TIMEOUT_EN.
- Defined: a cycle counter runs in RUN and clears on each event. When it reaches TIMEOUT_CYC, go to FAIL with fail_kind 1 and fail_pc = head PC. This catches a hung CPU or a trap loop.
- Undefined: no counter is built, and RUN may last indefinitely.

Decomposition:
- Package wbchk_pkg holds:
  - chk_state_e enum (IDLE, RUN, PASS, FAIL)
  - fail_kind_e enum
  - packed struct wb_entry_t {pc, reg, val, last}
- One sub-module, wbchk_fifo: a synchronous FIFO of wb_entry_t with full, empty and level outputs.
- Compare logic and the FSM stay in the top module.

Test Plan:
1. Push 3 entries: {0x00,x1,10}, {0x04,x2,0xFFFFFFFB}, {0x08,x3,5,last}. Pulse start and drive matching writebacks. Required: pass_cnt=3, state PASS, fail_kind 0.
2. Expect {0x0C,x4,15}; DUT writes {0x0C,x4,14}. Required: FAIL, fail_kind 3, fail_exp=15, fail_got=14, fail_pc=0x0C.
3. Expect {0x54,x19,1}; DUT writes at PC 0x50 (trap after a taken branch that failed). Required: fail_kind 1, fail_pc=0x50.
4. Push DEPTH entries with no pop. Required: exp_ready=0, fill_lvl=DEPTH. Then one match and a push in the same cycle: the push is refused, and exp_ready=1 the next cycle.
5. x0 writeback {0x8C,x0,0x90} interleaved with the trace. Required: ignored, pass_cnt unchanged. Also cpu_rst asserted mid-RUN: all outputs return to reset values.
6. With WBCHK_TIMEOUT_EN, TIMEOUT_CYC=20: start with entries queued and no writebacks. Required: FAIL with fail_kind 1 exactly 20 cycles after entering RUN.
